cop_mem_responder: RTL

Memory-side responder for the floating-point coprocessor's load/store port. Accepts one word request at a time (store data as four byte lanes, or a load), services it against an internal byte-addressed array after a fixed programmable latency, and returns load data on the same four-byte-lane format the coprocessor consumes. Sits between the coprocessor datapath and data storage, replacing an ideal zero-latency memory with a handshaked, multi-cycle one.

---
 rtl/cop_mem_pkg.sv | 15 +
 rtl/cop_byte_ram.sv | 42 ++++
 rtl/cop_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cop_mem_pkg.sv
// Shared types for the coprocessor load/store port and its memory responder.
// Byte lanes are unpacked: lane 0 is the least significant byte of the word.
package cop_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } cop_mem_state_t;

    typedef logic [7:0] byte_lanes_t [0:WORD_BYTES-1];

endpackage

// File: rtl/cop_byte_ram.sv
// Byte-addressed array with 4-lane word write and registered 4-lane read.
// Latency: write commits and read data registers on the enabling edge.
// Backpressure: none, the caller sequences we/re itself.
module cop_byte_ram
    import cop_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  byte_lanes_t   wdata,
    output byte_lanes_t   rdata
);

    logic [7:0] mem [0:MEM_BYTES-1];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem[addr + AW'(i)] <= wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                rdata[i] <= 8'h00;
            end
        end else if (re) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                rdata[i] <= mem[addr + AW'(i)];
            end
        end
    end

endmodule

// File: rtl/cop_mem_responder.sv
// Load/store responder: one word request in flight, serviced after LATENCY cycles.
// Latency: resp_valid LATENCY cycles after accept (1 cycle for error accesses).
// Backpressure: response held until resp_ready; req_ready low while busy or halted.
module cop_mem_responder
    import cop_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halted,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  byte_lanes_t wr_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_error,
    output byte_lanes_t rd_data
);

    localparam int            AW        = $clog2(MEM_BYTES);
    localparam int            CW        = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_LOAD  = CW'(LATENCY - 1);
    localparam bit            ZERO_WAIT = (LATENCY == 1);

    cop_mem_state_t state, state_n;
    logic [CW-1:0]  lat_cnt, lat_cnt_n;
    logic           resp_error_n;
    logic           cap_write;
    logic [AW-1:0]  cap_addr;
    byte_lanes_t    cap_data;

    logic           accept;
    logic           req_bad;
    logic           ram_we;
    logic           ram_re;
    logic [AW-1:0]  ram_addr;
    byte_lanes_t    ram_wdata;

    assign req_ready  = (state == IDLE) && !halted;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign req_bad    = (req_addr[1:0] != 2'b00) ||
                        (req_addr > 32'(MEM_BYTES - WORD_BYTES));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            resp_error <= 1'b0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            for (int i = 0; i < WORD_BYTES; i++) begin
                cap_data[i] <= 8'h00;
            end
        end else begin
            state      <= state_n;
            lat_cnt    <= lat_cnt_n;
            resp_error <= resp_error_n;
            if (accept) begin
                cap_write <= req_write;
                cap_addr  <= req_addr[AW-1:0];
                cap_data  <= wr_data;
            end
        end
    end

    // The array is touched only on the edge that enters RESP; with a single-cycle
    // latency that is the accept edge, so the live request fields feed the array.
    always_comb begin
        state_n      = state;
        lat_cnt_n    = lat_cnt;
        resp_error_n = resp_error;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = cap_addr;
        ram_wdata    = cap_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_n      = RESP;
                        resp_error_n = 1'b1;
                    end else begin
                        resp_error_n = 1'b0;
                        lat_cnt_n    = LAT_LOAD;
                        if (ZERO_WAIT) begin
                            state_n   = RESP;
                            ram_we    = req_write;
                            ram_re    = !req_write;
                            ram_addr  = req_addr[AW-1:0];
                            ram_wdata = wr_data;
                        end else begin
                            state_n = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                lat_cnt_n = lat_cnt - CW'(1);
                if (lat_cnt == CW'(1)) begin
                    state_n = RESP;
                    ram_we  = cap_write;
                    ram_re  = !cap_write;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_n      = IDLE;
                    resp_error_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    cop_byte_ram #(
        .MEM_BYTES (MEM_BYTES)
    ) u_ram (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rd_data)
    );

endmodule
